seq_right_shifter32: RTL and testbench
======================================

Name: seq_right_shifter32

Overview:
- Multi-cycle 32-bit right shifter. It is the right-direction counterpart of the combinational left barrel shifter in the ALU32 gate-level shifter path.
- Supports logical and arithmetic right shift and shifts one bit position per enabled clock.
- Uses a Start/Busy/Done handshake and feeds the ALU result mux for SRL/SRA operations where area matters more than latency.

Parameters:
- WIDTH, 32, data width; fixed at 32 for ALU32.
- SHW, 5, shift-amount width; only In2[SHW-1:0] is used.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In1  input  32  operand to shift.
- In2  input  32  shift amount; only bits [4:0] are used, bits [31:5] are ignored.
- Arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); sampled at Start.
- Start  input  1  request; accepted only in IDLE with Enable=1.
- Enable  input  1  high = enable; low stalls the block and forces Out to 0.
- Busy  output  1  high in SHIFT and DONE states.
- Done  output  1  high while in DONE state; result valid.
- Out  output  32  result register AND Enable, bitwise.

Behaviour:
- Reset (async, high): state=IDLE, result reg=0, count=0, arith flag=0. Outputs Busy=0, Done=0, Out=0. Reset mid-operation aborts immediately; no Done is produced.
- Registered state: result reg R[31:0], count C[4:0], arith flag A, and state in {IDLE, SHIFT, DONE}.
- All transitions below require Enable=1 at the rising edge. With Enable=0, every register holds (stall) and Out=0, but Busy/Done still reflect the state.
- IDLE + Start:
  - R<=In1, C<=In2[4:0], A<=Arith.
  - Next state is SHIFT if In2[4:0]!=0, else DONE.
  - Start while not in IDLE is ignored; no queueing.
- SHIFT, each edge:
  - R<={A?R[31]:1'b0, R[31:1]}, C<=C-1.
  - If C==1, next state is DONE; otherwise stay in SHIFT.
- DONE: Done=1 for exactly one enabled cycle, then IDLE on the next enabled edge.
  - Start is not accepted in DONE; the earliest new accept is the first IDLE cycle.
- R holds the result after DONE until the next accepted Start, so Out stays valid in IDLE while Enable=1.
- Latency: with shift amount N sampled at edge k, Done is high in the cycle after edge k+N, i.e. N+1 cycles after the accept edge with no stalls. N=0 gives Done one cycle after accept with R=In1.
- Arithmetic rules:
  - Logical: R = In1 >> N.
  - Arithmetic: R = signed In1 >>> N; sign bit replicated each step.
  - N=31 arithmetic on a negative operand gives 0xFFFFFFFF.
- Busy=1 in SHIFT and DONE; Busy=0 in IDLE.
- Out gating is combinational: Out[i] = R[i] & Enable.

Test Plan:
- Logical N=31: In1=0x80000000, In2=31, Arith=0, Start pulse → Busy high, Done high 32 cycles after accept, Out=0x00000001.
- Arithmetic N=4: In1=0x80000000, In2=4, Arith=1 → Done after 5 cycles, Out=0xF8000000. Repeat with In1=0x7FFFFFF0 → Out=0x07FFFFFF.
- Zero shift and ignored high bits:
  - In1=0x12345678, In2=0 → Done next cycle, Out=0x12345678.
  - In2=0x25 → shift by 5, Out=0x0091A2B3.
- Busy handling: re-assert Start with new operands during SHIFT and DONE → ignored; result matches the first request. Start in the first IDLE cycle after Done is accepted.
- Stall: In1=0xF0000000, In2=8, Arith=1; drop Enable for 3 cycles mid-SHIFT → Out=0 during the stall, Done delayed by exactly 3 cycles, final Out=0xFFF00000.
- Async reset: assert Reset between clock edges during SHIFT → Busy=0, Done=0, Out=0 immediately. After release, a new request completes correctly.

Source files
------------

// File: rtl/seq_right_shifter32.sv
// Multi-cycle right shifter: one bit position per enabled clock, logical or arithmetic.
// A Start in IDLE loads the operand, the shift count and the fill mode. The shifter then
// steps through SHIFT and spends one cycle in DONE. The result register keeps its value
// until the next accepted Start.
module seq_right_shifter32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Arith,
  input  logic             Start,
  input  logic             Enable,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic [SHW-1:0]   r_count;
  logic [SHW-1:0]   w_count_next;
  logic             r_arith;
  logic             w_arith_next;
  logic             w_fill;

  // Only the low SHW bits of the shift amount matter; the upper bits are deliberately dropped.
  logic w_unused;
  assign w_unused = ^In2[WIDTH-1:SHW];

  // Bit shifted in at the top: a copy of the sign in arithmetic mode, otherwise zero.
  assign w_fill = r_arith & r_result[WIDTH-1];

  // Next-state logic. Every register holds its value while Enable is low.
  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    w_count_next  = r_count;
    w_arith_next  = r_arith;
    if (Enable) begin
      unique case (r_state)
        StIdle: begin
          if (Start) begin
            w_result_next = In1;
            w_count_next  = In2[SHW-1:0];
            w_arith_next  = Arith;
            w_state_next  = (In2[SHW-1:0] != '0) ? StShift : StDone;
          end
        end
        StShift: begin
          w_result_next = {w_fill, r_result[WIDTH-1:1]};
          w_count_next  = r_count - SHW'(1);
          if (r_count == SHW'(1)) begin
            w_state_next = StDone;
          end
        end
        StDone: begin
          // Start is ignored here; the first IDLE cycle is the earliest new accept.
          w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers. An asynchronous reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_count  <= '0;
      r_arith  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
      r_count  <= w_count_next;
      r_arith  <= w_arith_next;
    end
  end

  // Status decodes from state. The result is forced to zero whenever Enable is low.
  always_comb begin
    Busy = (r_state != StIdle);
    Done = (r_state == StDone);
    Out  = r_result & {WIDTH{Enable}};
  end

endmodule

// File: tb/tb_seq_right_shifter32.sv
// Directed bench for seq_right_shifter32. It uses a table of single operations, followed
// by hand-written sequences for busy handling, stall behaviour and asynchronous reset.
module tb_seq_right_shifter32;

  logic        Clk;
  logic        Reset;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        Arith;
  logic        Start;
  logic        Enable;
  logic        Busy;
  logic        Done;
  logic [31:0] Out;

  int n_cmp;
  int n_err;

  seq_right_shifter32 #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .In1   (In1),
    .In2   (In2),
    .Arith (Arith),
    .Start (Start),
    .Enable(Enable),
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at the negedge numbered j0 after the accept edge. The bench expects Done
  // to appear at negedge number exp_j.
  task automatic wait_done(input int j0, input int exp_j, input string name);
    int j;
    j = j0;
    while (Done !== 1'b1 && j < j0 + 60) begin
      @(negedge Clk);
      j++;
    end
    n_cmp++;
    if (Done !== 1'b1 || j != exp_j) begin
      n_err++;
      $display("FAIL %s: done seen at cycle %0d (done=%b), expected cycle %0d", name, j, Done,
               exp_j);
    end
  endtask

  // Performs one complete operation. It starts and ends at a negedge while the DUT is idle.
  task automatic run_op(input int idx, input logic [31:0] in1, input logic [31:0] in2,
                        input logic arith, input logic [31:0] exp);
    string tag;
    int    lat;
    lat = int'(in2[4:0]) + 1;
    tag = $sformatf("vec%0d", idx);
    In1   = in1;
    In2   = in2;
    Arith = arith;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    In1   = 32'hA5A5_A5A5;
    In2   = 32'h0000_0007;
    Arith = ~arith;
    check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    wait_done(1, lat, {tag, "_latency"});
    check({tag, "_out"}, Out, exp);
    @(negedge Clk);
    check({tag, "_idle"}, {30'd0, Busy, Done}, 32'd0);
    check({tag, "_hold"}, Out, exp);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    Reset  = 1'b1;
    In1    = '0;
    In2    = '0;
    Arith  = 1'b0;
    Start  = 1'b0;
    Enable = 1'b1;

    vecs[0] = '{in1: 32'h8000_0000, in2: 32'd31,         arith: 1'b0, exp: 32'h0000_0001};
    vecs[1] = '{in1: 32'h8000_0000, in2: 32'd4,          arith: 1'b1, exp: 32'hF800_0000};
    vecs[2] = '{in1: 32'h7FFF_FFF0, in2: 32'd4,          arith: 1'b1, exp: 32'h07FF_FFFF};
    vecs[3] = '{in1: 32'h1234_5678, in2: 32'd0,          arith: 1'b0, exp: 32'h1234_5678};
    vecs[4] = '{in1: 32'h1234_5678, in2: 32'h0000_0025,  arith: 1'b0, exp: 32'h0091_A2B3};
    vecs[5] = '{in1: 32'h8000_0000, in2: 32'd31,         arith: 1'b1, exp: 32'hFFFF_FFFF};
    vecs[6] = '{in1: 32'hDEAD_BEEF, in2: 32'hFFFF_FFE8,  arith: 1'b1, exp: 32'hFFDE_ADBE};
    vecs[7] = '{in1: 32'hDEAD_BEEF, in2: 32'd1,          arith: 1'b0, exp: 32'h6F56_DF77};
    vecs[8] = '{in1: 32'h0000_0001, in2: 32'd1,          arith: 1'b1, exp: 32'h0000_0000};

    // Reset state
    @(negedge Clk);
    check("reset_status", {30'd0, Busy, Done}, 32'd0);
    check("reset_out", Out, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 9; i++) begin
      run_op(i, vecs[i].in1, vecs[i].in2, vecs[i].arith, vecs[i].exp);
    end

    // Enable gating of the held result while idle
    Enable = 1'b0;
    #1;
    check("idle_gate_out", Out, 32'd0);
    check("idle_gate_busy", {31'd0, Busy}, 32'd0);
    Enable = 1'b1;
    #1;
    check("idle_ungate_out", Out, 32'h0000_0000);
    @(negedge Clk);
    run_op(9, 32'hCAFE_0000, 32'd16, 1'b0, 32'h0000_CAFE);
    Enable = 1'b0;
    #1;
    check("idle_gate_out2", Out, 32'd0);
    Enable = 1'b1;
    #1;
    check("idle_ungate_out2", Out, 32'h0000_CAFE);
    @(negedge Clk);

    // Start asserted during SHIFT and DONE must be ignored
    In1   = 32'h8000_0000;
    In2   = 32'd3;
    Arith = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    In1   = 32'hFFFF_FFFF;
    In2   = 32'd0;
    Arith = 1'b1;
    wait_done(1, 4, "busy_ign_latency");
    check("busy_ign_out", Out, 32'h1000_0000);
    In1   = 32'h0000_0100;
    In2   = 32'd2;
    Arith = 1'b0;
    @(negedge Clk);
    check("busy_ign_idle", {30'd0, Busy, Done}, 32'd0);
    check("busy_ign_hold", Out, 32'h1000_0000);
    @(negedge Clk);
    Start = 1'b0;
    check("first_idle_accept", {31'd0, Busy}, 32'd1);
    wait_done(1, 3, "first_idle_latency");
    check("first_idle_out", Out, 32'h0000_0040);
    @(negedge Clk);

    // Stall: Enable low for 3 edges in the middle of SHIFT
    In1   = 32'hF000_0000;
    In2   = 32'd8;
    Arith = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Enable = 1'b0;
    #1;
    check("stall_out_zero", Out, 32'd0);
    @(negedge Clk);
    check("stall_busy", {30'd0, Busy, Done}, 32'd2);
    check("stall_out_zero2", Out, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Enable = 1'b1;
    wait_done(6, 12, "stall_latency");
    check("stall_out", Out, 32'hFFF0_0000);
    @(negedge Clk);

    // Asynchronous reset asserted between edges while in SHIFT
    In1   = 32'h8000_0000;
    In2   = 32'd20;
    Arith = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("areset_status", {30'd0, Busy, Done}, 32'd0);
    check("areset_out", Out, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("areset_no_done", {30'd0, Busy, Done}, 32'd0);
    run_op(10, 32'h0000_FF00, 32'd8, 1'b0, 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
